// File: rtl/hit_timestamper.sv
// Captures hits from an external SR latch, stamps them with a free-running coarse
// counter and queues the stamps in a first-word fall-through FIFO.
module hit_timestamper #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_q,
  output logic             latch_rst,
  output logic [CNT_W-1:0] ts_data,
  output logic             ts_valid,
  input  logic             ts_ready,
  output logic             dropped,
  output logic             wrap
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_CLEAR,
    S_HOLD
  } state_t;

  logic             sync_meta_reg;
  logic             hit_s;
  logic [CNT_W-1:0] cnt_reg;
  logic             wrap_reg;

  state_t           state_reg, state_next;
  logic [HW-1:0]    hold_reg, hold_next;
  logic [CNT_W-1:0] stamp_reg, stamp_next;
  logic             latch_rst_reg;
  logic             dropped_reg;
  logic             push;
  logic             drop;

  logic [CNT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      rd_succ;
  logic [CNT_W-1:0] ts_data_reg;
  logic             empty;
  logic             full;
  logic             pop;

  // hit_q is asynchronous; only hit_s is used below
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta_reg <= 1'b0;
      hit_s         <= 1'b0;
    end else begin
      sync_meta_reg <= hit_q;
      hit_s         <= sync_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_reg + CNT_W'(1);
      wrap_reg <= &cnt_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    stamp_next = stamp_reg;
    push       = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (hit_s) begin
          stamp_next = cnt_reg;
          state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // a same-cycle pop frees the slot, so a full FIFO still accepts the stamp
        if (!full || pop) begin
          push = 1'b1;
        end else begin
          drop = 1'b1;
        end
        state_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (!hit_s) begin
          hold_next  = '0;
          state_next = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = S_IDLE;
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_CLEAR;
      hold_reg      <= '0;
      stamp_reg     <= '0;
      latch_rst_reg <= 1'b1;
      dropped_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      stamp_reg     <= stamp_next;
      latch_rst_reg <= (state_next == S_CLEAR);
      if (drop) begin
        dropped_reg <= 1'b1;
      end
    end
  end

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop     = !empty && ts_ready;
  assign rd_succ = rd_ptr_reg + (AW + 1)'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= stamp_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_succ;
      end
    end
  end

  // Head register: loads the incoming stamp when it becomes the head, else the next entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_data_reg <= '0;
    end else if (push && (empty || (pop && rd_succ == wr_ptr_reg))) begin
      ts_data_reg <= stamp_reg;
    end else if (pop && rd_succ != wr_ptr_reg) begin
      ts_data_reg <= mem[rd_succ[AW-1:0]];
    end
  end

  assign latch_rst = latch_rst_reg;
  assign ts_data   = ts_data_reg;
  assign ts_valid  = !empty;
  assign dropped   = dropped_reg;
  assign wrap      = wrap_reg;

endmodule

// File: tb/tb_hit_timestamper.sv
// Directed bench for hit_timestamper: a default instance and a CNT_W=4 instance for rollover.
module tb_hit_timestamper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hit_q;
  logic        latch_rst;
  logic [15:0] ts_data;
  logic        ts_valid;
  logic        ts_ready;
  logic        dropped;
  logic        wrap;

  logic        rst_n_w;
  logic        hit_q_w;
  logic        latch_rst_w;
  logic [3:0]  ts_data_w;
  logic        ts_valid_w;
  logic        ts_ready_w;
  logic        dropped_w;
  logic        wrap_w;

  // reference copies of the coarse counters, which are not visible on the ports
  logic [15:0] mcnt;
  logic [3:0]  mcw;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_ts [5];

  hit_timestamper #(.CNT_W(16), .FIFO_DEPTH(4), .HOLDOFF(2)) dut (
    .clk(clk), .rst_n(rst_n), .hit_q(hit_q), .latch_rst(latch_rst),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .dropped(dropped), .wrap(wrap)
  );

  hit_timestamper #(.CNT_W(4), .FIFO_DEPTH(4), .HOLDOFF(2)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .hit_q(hit_q_w), .latch_rst(latch_rst_w),
    .ts_data(ts_data_w), .ts_valid(ts_valid_w), .ts_ready(ts_ready_w),
    .dropped(dropped_w), .wrap(wrap_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) mcnt <= 16'd0;
    else        mcnt <= mcnt + 16'd1;
    if (!rst_n_w) mcw <= 4'd0;
    else          mcw <= mcw + 4'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise hit_q, release it once the latch is being cleared, pad to 10 cycles
  task automatic do_hit(output logic [15:0] ts_exp, output bit seen);
    int k;
    ts_exp = mcnt + 16'd2;
    hit_q  = 1'b1;
    k      = 0;
    seen   = 1'b0;
    while (k < 8 && !seen) begin
      tick();
      k++;
      seen = latch_rst;
    end
    hit_q = 1'b0;
    while (k < 10) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hit_q = 1'b0; ts_ready = 1'b0;
    tick(); tick();
    total++; if (latch_rst !== 1'b1) begin bad++; $display("FAIL reset_latch_rst: got %b want 1", latch_rst); end
    total++; if (ts_valid !== 1'b0) begin bad++; $display("FAIL reset_ts_valid: got %b want 0", ts_valid); end
    total++; if (ts_data !== 16'd0) begin bad++; $display("FAIL reset_ts_data: got %0d want 0", ts_data); end
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    // hit arrives at release: it lands during holdoff and is stamped on IDLE entry (counter=3)
    rst_n = 1'b1; hit_q = 1'b1;
    tick();
    total++; if (latch_rst !== 1'b0) begin bad++; $display("FAIL reset_rearm: got %b want 0", latch_rst); end
    tick(); tick(); tick();
    total++; if (ts_valid !== 1'b0) begin bad++; $display("FAIL reset_early_valid: got %b want 0", ts_valid); end
    tick();
    total++; if (ts_valid !== 1'b1) begin bad++; $display("FAIL holdoff_valid: got %b want 1", ts_valid); end
    total++; if (ts_data !== 16'd3) begin bad++; $display("FAIL holdoff_stamp: got %0d want 3", ts_data); end
    total++; if (latch_rst !== 1'b1) begin bad++; $display("FAIL holdoff_latch_rst: got %b want 1", latch_rst); end
    $display("reset: ts_valid=%b ts_data=%0d latch_rst=%b", ts_valid, ts_data, latch_rst);
    hit_q = 1'b0; ts_ready = 1'b1;
    tick();
    total++; if (ts_valid !== 1'b0) begin bad++; $display("FAIL holdoff_pop: got %b want 0", ts_valid); end
    repeat (10) tick();
  endtask

  task automatic test_single_hit();
    int k;
    int vcnt;
    int lcnt;
    logic [15:0] got;
    k = 0;
    while (mcnt != 16'd100 && k < 200) begin tick(); k++; end
    total++; if (mcnt !== 16'd100) begin bad++; $display("FAIL single_sync: counter model got %0d want 100", mcnt); end
    hit_q = 1'b1; vcnt = 0; lcnt = 0; got = 16'hffff;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (ts_valid) begin vcnt++; got = ts_data; end
      if (latch_rst) begin lcnt++; hit_q = 1'b0; end
    end
    total++; if (got !== 16'd102) begin bad++; $display("FAIL single_stamp: got %0d want 102", got); end
    total++; if (vcnt != 1) begin bad++; $display("FAIL single_valid_len: got %0d want 1", vcnt); end
    total++; if (lcnt != 3) begin bad++; $display("FAIL single_latch_len: got %0d want 3", lcnt); end
    $display("single hit: ts_data=%0d valid_cycles=%0d latch_cycles=%0d", got, vcnt, lcnt);
  endtask

  task automatic test_held_hit();
    int pops;
    logic [15:0] want;
    logic [15:0] got;
    logic exp_l;
    want = mcnt + 16'd2; got = 16'hffff; pops = 0;
    hit_q = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      exp_l = (t >= 4 && t <= 22);
      total++; if (latch_rst !== exp_l) begin bad++; $display("FAIL held_latch_rst t=%0d: got %b want %b", t, latch_rst, exp_l); end
      if (ts_valid) begin pops++; got = ts_data; end
      if (t == 20) hit_q = 1'b0;
    end
    total++; if (pops != 1) begin bad++; $display("FAIL held_count: got %0d want 1", pops); end
    total++; if (got !== want) begin bad++; $display("FAIL held_stamp: got %0d want %0d", got, want); end
    $display("held hit: pops=%0d ts_data=%0d", pops, got);
  endtask

  task automatic test_overflow();
    bit seen;
    ts_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      do_hit(exp_ts[h], seen);
      total++; if (!seen) begin bad++; $display("FAIL overflow_latch h=%0d: got 0 want 1", h); end
      if (h == 3) begin
        total++; if (dropped !== 1'b0) begin bad++; $display("FAIL overflow_early_drop: got %b want 0", dropped); end
      end
    end
    total++; if (dropped !== 1'b1) begin bad++; $display("FAIL overflow_dropped: got %b want 1", dropped); end
    ts_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ts_valid !== 1'b1 || ts_data !== exp_ts[i]) begin
        bad++; $display("FAIL overflow_drain i=%0d: got valid=%b data=%0d want valid=1 data=%0d", i, ts_valid, ts_data, exp_ts[i]);
      end
      $display("overflow drain %0d: ts_data=%0d", i, ts_data);
      tick();
    end
    total++; if (ts_valid !== 1'b0) begin bad++; $display("FAIL overflow_empty: got %b want 0", ts_valid); end
    total++; if (dropped !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b want 1", dropped); end
    ts_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int k;
    ts_ready = 1'b0;
    do_hit(exp_ts[0], seen);
    do_hit(exp_ts[1], seen);
    hit_q = 1'b1; k = 0;
    while (!latch_rst && k < 8) begin tick(); k++; end
    total++; if (latch_rst !== 1'b1) begin bad++; $display("FAIL mid_in_clear: got %b want 1", latch_rst); end
    rst_n = 1'b0; hit_q = 1'b0;
    tick();
    total++; if (ts_valid !== 1'b0) begin bad++; $display("FAIL mid_ts_valid: got %b want 0", ts_valid); end
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL mid_dropped: got %b want 0", dropped); end
    total++; if (latch_rst !== 1'b1) begin bad++; $display("FAIL mid_latch_rst: got %b want 1", latch_rst); end
    total++; if (ts_data !== 16'd0) begin bad++; $display("FAIL mid_ts_data: got %0d want 0", ts_data); end
    $display("mid reset: ts_valid=%b dropped=%b latch_rst=%b", ts_valid, dropped, latch_rst);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    total++; if (ts_valid !== 1'b0) begin bad++; $display("FAIL mid_stays_empty: got %b want 0", ts_valid); end
  endtask

  task automatic test_full_pop();
    bit seen;
    ts_ready = 1'b0;
    for (int h = 0; h < 4; h++) begin
      do_hit(exp_ts[h], seen);
    end
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL fullpop_pre_drop: got %b want 0", dropped); end
    exp_ts[4] = mcnt + 16'd2;
    hit_q = 1'b1;
    tick(); tick(); tick();
    // CAPTURE cycle: pop the head in the same cycle as the push
    total++; if (ts_data !== exp_ts[0]) begin bad++; $display("FAIL fullpop_head: got %0d want %0d", ts_data, exp_ts[0]); end
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    total++; if (latch_rst !== 1'b1) begin bad++; $display("FAIL fullpop_latch: got %b want 1", latch_rst); end
    hit_q = 1'b0;
    repeat (6) tick();
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL fullpop_dropped: got %b want 0", dropped); end
    ts_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      total++;
      if (ts_valid !== 1'b1 || ts_data !== exp_ts[i]) begin
        bad++; $display("FAIL fullpop_drain i=%0d: got valid=%b data=%0d want valid=1 data=%0d", i, ts_valid, ts_data, exp_ts[i]);
      end
      $display("full+pop drain %0d: ts_data=%0d", i, ts_data);
      tick();
    end
    total++; if (ts_valid !== 1'b0) begin bad++; $display("FAIL fullpop_count: got valid=%b want 0 after 4 pops", ts_valid); end
  endtask

  task automatic test_wrap();
    int k;
    bit seen;
    logic [3:0] got;
    logic exp_w;
    tick();
    total++; if (wrap_w !== 1'b0) begin bad++; $display("FAIL wrap_reset: got %b want 0", wrap_w); end
    rst_n_w = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_w = (t == 16);
      total++; if (wrap_w !== exp_w) begin bad++; $display("FAIL wrap_pulse t=%0d: got %b want %b", t, wrap_w, exp_w); end
    end
    k = 0;
    while (mcw != 4'd14 && k < 20) begin tick(); k++; end
    // stamp is taken two cycles later, right on the rollover to 0
    hit_q_w = 1'b1; seen = 1'b0; got = 4'hf;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (ts_valid_w && !seen) begin seen = 1'b1; got = ts_data_w; end
      if (latch_rst_w) hit_q_w = 1'b0;
    end
    total++; if (!seen) begin bad++; $display("FAIL wrap_hit_valid: got 0 want 1"); end
    total++; if (got !== 4'd0) begin bad++; $display("FAIL wrap_hit_stamp: got %0d want 0", got); end
    $display("wrap hit: seen=%b ts_data=%0d", seen, got);
  endtask

  initial begin
    rst_n = 1'b0; hit_q = 1'b0; ts_ready = 1'b0;
    rst_n_w = 1'b0; hit_q_w = 1'b0; ts_ready_w = 1'b1;
    test_reset();
    test_single_hit();
    test_held_hit();
    test_overflow();
    test_reset_mid();
    test_full_pop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
